// File: rtl/uart_flit_tx_if.sv
// uart_flit_tx_if: valid/ready flit handshake into the UART flit transmitter
interface uart_flit_tx_if #(parameter int FLIT_WIDTH = 128);
  logic [FLIT_WIDTH-1:0] flit_in;
  logic                  flit_in_valid;
  logic                  flit_in_ready;
  modport master (output flit_in, output flit_in_valid, input flit_in_ready);
  modport slave (input flit_in, input flit_in_valid, output flit_in_ready);
endinterface

// File: rtl/uart_flit_tx.sv
// uart_flit_tx: serializes one flit onto an 8N1 UART line, LSB byte and LSB bit first
module uart_flit_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FLIT_WIDTH = 128
) (
  input  logic               cpuclk,
  input  logic               rst,
  uart_flit_tx_if.slave      s_flit,
  output logic               uart_tx,
  output logic               busy
);
  localparam int NUM_BYTES = FLIT_WIDTH / 8;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t                r_state, w_state;
  logic [FLIT_WIDTH-1:0] r_shift, w_shift;
  logic [CW-1:0]         r_baud, w_baud;
  logic [2:0]            r_bit, w_bit;
  logic [BW-1:0]         r_byte, w_byte;
  logic                  w_tick;
  logic [BW+2:0]         w_idx;
  assign w_tick = r_baud == CW'(CLKS_PER_BIT - 1);
  assign w_idx = {r_byte, r_bit};
  always_ff @(posedge cpuclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_baud <= '0;
      r_bit <= '0;
      r_byte <= '0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_baud <= w_baud;
      r_bit <= w_bit;
      r_byte <= w_byte;
    end
  end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_baud = w_tick ? '0 : r_baud + CW'(1);
    w_bit = r_bit;
    w_byte = r_byte;
    case (r_state)
      IDLE: begin
        w_baud = '0;
        if (s_flit.flit_in_valid) begin
          w_state = START;
          w_shift = s_flit.flit_in;
          w_bit = '0;
          w_byte = '0;
        end
      end
      START: begin
        w_state = w_tick ? DATA : START;
        w_bit = w_tick ? 3'd0 : r_bit;
      end
      DATA: begin
        w_state = w_tick && r_bit == 3'd7 ? STOP : DATA;
        w_bit = w_tick && r_bit != 3'd7 ? r_bit + 3'd1 : r_bit;
      end
      STOP: begin
        if (w_tick) begin
          w_state = r_byte == BW'(NUM_BYTES - 1) ? IDLE : START;
          w_byte = r_byte == BW'(NUM_BYTES - 1) ? r_byte : r_byte + BW'(1);
        end
      end
      default: w_state = IDLE;
    endcase
  end
  assign s_flit.flit_in_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign uart_tx = r_state == START ? 1'b0 : r_state == DATA ? r_shift[w_idx] : 1'b1;
endmodule

// File: tb/tb_uart_flit_tx.sv
// tb_uart_flit_tx: directed table-driven and sequence checks of the flit UART transmitter
module tb_uart_flit_tx;
  logic clk = 1'b0;
  logic rst;
  logic uart_tx, busy;
  int total = 0;
  int bad = 0;
  uart_flit_tx_if #(.FLIT_WIDTH(128)) bus ();
  uart_flit_tx #(.CLKS_PER_BIT(4), .FLIT_WIDTH(128)) dut (
    .cpuclk(clk), .rst(rst), .s_flit(bus), .uart_tx(uart_tx), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [127:0] flit;
    logic [7:0]   first_byte;
    logic [7:0]   last_byte;
    string        name;
  } vec_t;
  vec_t vecs[4];
  localparam logic [127:0] COUNT_FLIT = 128'h0F0E0D0C0B0A09080706050403020100;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic watch_frame(input logic [127:0] ef, input string nm, output logic [127:0] got);
    int werr, rerr, ferr, b, k, p;
    logic e;
    logic [159:0] cen;
    werr = 0;
    rerr = 0;
    ferr = 0;
    cen = '0;
    got = '0;
    for (int i = 1; i <= 640; i++) begin
      @(negedge clk);
      b = (i - 1) / 4;
      k = b / 10;
      p = b % 10;
      e = p == 0 ? 1'b0 : p == 9 ? 1'b1 : ef[8 * k + p - 1];
      if (uart_tx !== e) werr++;
      if (bus.flit_in_ready !== 1'b0 || busy !== 1'b1) rerr++;
      if ((i - 1) % 4 == 2) cen[b] = uart_tx;
    end
    for (int j = 0; j < 16; j++) begin
      if (cen[10 * j] !== 1'b0 || cen[10 * j + 9] !== 1'b1) ferr++;
      got[8 * j +: 8] = cen[10 * j + 1 +: 8];
    end
    chk({nm, " wave_errs"}, werr, 0);
    chk({nm, " busy_errs"}, rerr, 0);
    chk({nm, " frame_errs"}, ferr, 0);
    chk({nm, " decoded"}, got, ef);
    @(negedge clk);
    chk({nm, " ready_at_641"}, {busy, bus.flit_in_ready}, 2'b01);
  endtask
  task automatic handshake(input logic [127:0] f, input string nm);
    @(posedge clk);
    #1;
    bus.flit_in = f;
    bus.flit_in_valid = 1'b1;
    @(negedge clk);
    chk({nm, " ready_before"}, bus.flit_in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [127:0] got, got2;
    int hi;
    vecs[0] = '{COUNT_FLIT, 8'h00, 8'h0F, "count"};
    vecs[1] = '{{16{8'hA5}}, 8'hA5, 8'hA5, "a5"};
    vecs[2] = '{{128{1'b1}}, 8'hFF, 8'hFF, "ones"};
    vecs[3] = '{128'h0123456789ABCDEFFEDCBA9876543210, 8'h10, 8'h01, "mixed"};
    rst = 1'b1;
    bus.flit_in_valid = 1'b1;
    bus.flit_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.flit_in = {$urandom, $urandom, $urandom, $urandom};
      bus.flit_in_valid = 1'($urandom_range(0, 1)) | (i == 2);
      @(negedge clk);
      chk("reset_hold", {uart_tx, bus.flit_in_ready, busy}, 3'b110);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.flit_in_valid = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b1 && bus.flit_in_ready === 1'b1) hi++;
    end
    chk("idle_after_reset", hi, 10);
    for (int v = 0; v < 4; v++) begin
      handshake(vecs[v].flit, vecs[v].name);
      bus.flit_in_valid = 1'b0;
      watch_frame(vecs[v].flit, vecs[v].name, got);
      chk({vecs[v].name, " first_byte"}, got[7:0], vecs[v].first_byte);
      chk({vecs[v].name, " last_byte"}, got[127:120], vecs[v].last_byte);
    end
    handshake(COUNT_FLIT, "b2b");
    bus.flit_in = vecs[3].flit;
    watch_frame(COUNT_FLIT, "b2b_first", got);
    @(posedge clk);
    #1;
    bus.flit_in_valid = 1'b0;
    bus.flit_in = '0;
    watch_frame(vecs[3].flit, "b2b_second", got2);
    handshake(COUNT_FLIT, "pulse");
    bus.flit_in_valid = 1'b0;
    fork
      watch_frame(COUNT_FLIT, "pulse", got);
      begin
        repeat (99) @(posedge clk);
        #1;
        bus.flit_in = {16{8'h3C}};
        bus.flit_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flit_in_valid = 1'b0;
      end
    join
    handshake(vecs[1].flit, "midrst");
    bus.flit_in_valid = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_t51", {uart_tx, bus.flit_in_ready, busy}, 3'b110);
    handshake(vecs[3].flit, "after_rst");
    bus.flit_in_valid = 1'b0;
    watch_frame(vecs[3].flit, "after_rst", got);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_flit_tx.md
# uart_flit_tx

UART transmitter for the interdevice link: accepts one `types::flit_t` over a valid/ready handshake and serializes it onto a single 8N1 UART line. It sits on the transmit side of `interdevice_controller` when built with `UART`. It drives `uart_tx` from `interdevice_tx_flit`/`interdevice_tx_valid` and returns `interdevice_tx_ready`. It is the sending end of the byte framing that the flit UART receiver decodes.

## Interface
- `CLKS_PER_BIT`, default 868: cpuclk cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `FLIT_WIDTH`, default `$bits(types::flit_t)` (128): flit width. Must be a multiple of 8. `NUM_BYTES = FLIT_WIDTH/8`.
- `cpuclk  in  1`: sole clock, rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `flit_in  in  FLIT_WIDTH`: flit to send, type `types::flit_t`.
- `flit_in_valid  in  1`: `flit_in` is valid.
- `flit_in_ready  out  1`: block can accept a flit this cycle.
- `uart_tx  out  1`: serial line, idle high.
- `busy  out  1`: frame in progress (`!flit_in_ready`).

## Operation
- FSM states: IDLE, START, DATA, STOP. Registers:
  - `shift_q[FLIT_WIDTH]`
  - `baud_cnt` (`$clog2(CLKS_PER_BIT)` bits)
  - `bit_idx` (3 bits)
  - `byte_idx` (`$clog2(NUM_BYTES)` bits)
- IDLE:
  - `uart_tx=1`, `flit_in_ready=1`.
  - On `flit_in_valid & flit_in_ready`: latch `flit_in` into `shift_q`, clear the counters, go to START.
  - `flit_in` is ignored in every other state.
- START: `uart_tx=0` for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx=0`.
- DATA:
  - `uart_tx = shift_q[byte_idx*8 + bit_idx]`. Bytes go out LSB byte first (`flit[7:0]` first), bits LSB first.
  - Each bit is held `CLKS_PER_BIT` cycles.
  - After bit 7, go to STOP.
- STOP: `uart_tx=1` for `CLKS_PER_BIT` cycles. Then:
  - if `byte_idx == NUM_BYTES-1`: go to IDLE;
  - otherwise increment `byte_idx` and go to START. There is no inter-byte gap.
- `baud_cnt` counts 0..`CLKS_PER_BIT-1`. The bit ends when `baud_cnt == CLKS_PER_BIT-1`, and the counter then wraps to 0. `bit_idx` and `byte_idx` wrap only via the state transitions above; they never overflow.
- No parity and no checksum generation. The flit is sent verbatim; the checksum is already in the flit.
- Reset:
  - Next cycle: state=IDLE, `uart_tx=1`, `flit_in_ready=1`, `busy=0`, all counters 0, `shift_q` 0.
  - Reset mid-frame abandons the flit. The partial byte on the line is truncated and there is no retry.
  - `rst` and `flit_in_valid` asserted together: reset wins, nothing is accepted.
- `flit_in_valid` dropping while in IDLE is legal and has no effect.

## Timing
- Outputs are registered or decoded from registered state only. There is no combinational path from `flit_in_valid` to `flit_in_ready`.
- Handshake at the edge ending cycle T0. Then:
  - cycles T0+1 .. T0+C: `uart_tx=0` (start bit of byte 0), where C = `CLKS_PER_BIT`;
  - byte k, bit j occupies cycles T0 + 1 + C·(10k + 1 + j) .. T0 + C·(10k + 2 + j);
  - stop bit of byte k occupies cycles T0 + 1 + C·(10k + 9) .. T0 + C·(10k + 10).
- The last stop bit ends at T0 + 160C (for 16 bytes). `flit_in_ready=1` in cycle T0 + 160C + 1.
- Minimum flit-to-flit period is 10·NUM_BYTES·C + 1 cycles.
- `flit_in_ready` falls in cycle T0+1, the same cycle the start bit begins.

## Test plan
All scenarios use `CLKS_PER_BIT=4`, `FLIT_WIDTH=128`.
- Reset: hold `rst` 3 cycles with random inputs → `uart_tx=1`, `flit_in_ready=1`, `busy=0` from the first cycle after reset.
- Single flit `128'h0F0E..0100` (byte k = k): a bench UART sampler at bit centres decodes bytes 0x00..0x0F in order. Start bits are low, stop bits high, each bit exactly 4 cycles. `flit_in_ready` returns at T0+641.
- Pattern check: flit all `8'hA5` bytes → each byte on the line is 1,0,1,0,0,1,0,1 (LSB first) between a 0 start bit and a 1 stop bit. 160 bit-times total.
- Back-to-back: `flit_in_valid` held high with two different flits → the second handshake occurs at cycle T0+641. The first flit is not corrupted by `flit_in` changing mid-frame.
- Mid-frame reset: assert `rst` for 1 cycle at T0+50 → `uart_tx=1` and `flit_in_ready=1` at T0+51. A new flit accepted afterwards is sent complete and correct.
- Valid while busy: pulse `flit_in_valid` with other data at T0+100 → ignored. The line output is identical to the single-flit case.
